// File: rtl/id_issue.sv
// Decode/issue stage: single-entry fetch buffer, 32x64 register file, pending-register scoreboard.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writebacks to operands and to the hazard check.
module id_issue #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_if_valid,
  input  logic [31:0]     i_if_inst,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_ready,
  output logic            o_inst_valid,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_inst_addr,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  input  logic            i_wbs_valid,
  input  logic [4:0]      i_wbs_rd,
  input  logic [XLEN-1:0] i_wbs_value,
  input  logic            i_wbl_valid,
  input  logic [4:0]      i_wbl_rd,
  input  logic [XLEN-1:0] i_wbl_value,
  input  logic            i_jmp_valid,
  output logic            o_halted
);

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALUR = 7'b0110011;
  localparam logic [6:0] OP_EOF  = 7'b1111111;

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_SD) || (op == OP_BR) ||
           (op == OP_ALUI) || (op == OP_ALUR);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == OP_SD) || (op == OP_BR) || (op == OP_ALUR);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_ALUI) || (op == OP_ALUR);
  endfunction

  logic            vld_p0;
  logic [31:0]     inst_p0;
  logic [XLEN-1:0] addr_p0;
  logic            br_wait;
  logic            halted;
  logic [NREG-1:0] sb_pend;
  logic [XLEN-1:0] rf [NREG];

  logic [6:0]      op;
  logic [4:0]      rd, rs1, rs2;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] pend_chk;
  logic [NREG-1:0] sb_set;
  logic            hazard;
  logic            issue;
  logic            if_ready;
  logic            accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign op  = inst_p0[6:0];
  assign rd  = inst_p0[11:7];
  assign rs1 = inst_p0[19:15];
  assign rs2 = inst_p0[24:20];

  always_comb begin
    wb_clr = '0;
    if (i_wbs_valid) wb_clr[i_wbs_rd] = 1'b1;
    if (i_wbl_valid) wb_clr[i_wbl_rd] = 1'b1;
    wb_clr[0] = 1'b0;
  end

`ifdef ID_WB_BYPASS_EN
  assign pend_chk = sb_pend & ~wb_clr;
`else
  assign pend_chk = sb_pend;
`endif

  assign hazard = (reads_rs1(op) && pend_chk[rs1]) ||
                  (reads_rs2(op) && pend_chk[rs2]) ||
                  (writes_rd(op) && pend_chk[rd]);

  assign issue    = !i_rst && vld_p0 && !hazard && !br_wait && !halted;
  assign if_ready = !i_rst && !halted && !br_wait && (!vld_p0 || issue);
  assign accept   = i_if_valid && if_ready;

  always_comb begin
    sb_set = '0;
    if (issue && writes_rd(op) && (rd != 5'd0)) sb_set[rd] = 1'b1;
  end

  // Operand read: register file, optionally overridden by a writeback landing this cycle
  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
`ifdef ID_WB_BYPASS_EN
    if (!i_rst && i_wbs_valid && (i_wbs_rd == rs1) && (rs1 != 5'd0)) rs1_val = i_wbs_value;
    if (!i_rst && i_wbl_valid && (i_wbl_rd == rs1) && (rs1 != 5'd0)) rs1_val = i_wbl_value;
    if (!i_rst && i_wbs_valid && (i_wbs_rd == rs2) && (rs2 != 5'd0)) rs2_val = i_wbs_value;
    if (!i_rst && i_wbl_valid && (i_wbl_rd == rs2) && (rs2 != 5'd0)) rs2_val = i_wbl_value;
`endif
  end

  // Buffer stage p0 and issue control; set beats clear on the scoreboard
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p0  <= 1'b0;
      inst_p0 <= '0;
      addr_p0 <= '0;
      br_wait <= 1'b0;
      halted  <= 1'b0;
      sb_pend <= '0;
    end else begin
      br_wait <= issue && (op == OP_BR);
      if (issue && (op == OP_EOF)) halted <= 1'b1;
      sb_pend <= (sb_pend & ~wb_clr) | sb_set;
      if (br_wait && i_jmp_valid) begin
        vld_p0 <= 1'b0;
      end else if (accept) begin
        vld_p0  <= 1'b1;
        inst_p0 <= i_if_inst;
        addr_p0 <= i_if_addr;
      end else if (issue) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (i_wbs_valid && (i_wbs_rd != 5'd0)) rf[i_wbs_rd] <= i_wbs_value;
      if (i_wbl_valid && (i_wbl_rd != 5'd0)) rf[i_wbl_rd] <= i_wbl_value;
    end
  end

  assign o_if_ready   = if_ready;
  assign o_inst_valid = issue;
  assign o_inst       = inst_p0;
  assign o_inst_addr  = addr_p0;
  assign o_rs1_value  = rs1_val;
  assign o_rs2_value  = rs2_val;
  assign o_halted     = halted;

endmodule

// File: tb/tb_id_issue.sv
// Bench for id_issue: per-cycle vector table, hand-written reset/halt sequences,
// and a randomized run checked against an in-order instruction-level model.
module tb_id_issue;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_ALUR = 7'b0110011;
`ifdef ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic [63:0] rs1_value, rs2_value;
  logic        wbs_valid, wbl_valid;
  logic [4:0]  wbs_rd, wbl_rd;
  logic [63:0] wbs_value, wbl_value;
  logic        jmp_valid;
  logic        halted;

  id_issue dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_valid(if_valid), .i_if_inst(if_inst), .i_if_addr(if_addr), .o_if_ready(if_ready),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_addr(inst_addr),
    .o_rs1_value(rs1_value), .o_rs2_value(rs2_value),
    .i_wbs_valid(wbs_valid), .i_wbs_rd(wbs_rd), .i_wbs_value(wbs_value),
    .i_wbl_valid(wbl_valid), .i_wbl_rd(wbl_rd), .i_wbl_value(wbl_value),
    .i_jmp_valid(jmp_valid), .o_halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- encoders and instruction semantics ----------------
  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, OP_ALUI};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_ALUR};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b011, 5'd0, OP_SD};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, OP_BR};
  endfunction

  function automatic void dec(input logic [31:0] in, output bit r1, output bit r2, output bit w);
    r1 = 0; r2 = 0; w = 0;
    case (in[6:0])
      OP_LD:   begin r1 = 1; w = 1; end
      OP_SD:   begin r1 = 1; r2 = 1; end
      OP_BR:   begin r1 = 1; r2 = 1; end
      OP_ALUI: begin r1 = 1; w = 1; end
      OP_ALUR: begin r1 = 1; r2 = 1; w = 1; end
      default: ;
    endcase
  endfunction

  // Result and writeback path of a writing instruction (long: add/sub/load)
  function automatic void exec(input logic [31:0] in, input logic [63:0] a, input logic [63:0] b,
                               output logic [63:0] v, output bit lng);
    logic [63:0] imm;
    imm = {{52{in[31]}}, in[31:20]};
    v = '0; lng = 0;
    if (in[6:0] == OP_LD) begin
      v = {$urandom, $urandom}; lng = 1;
    end else begin
      if (in[6:0] == OP_ALUR) imm = b;
      case (in[14:12])
        3'b100:  v = a ^ imm;
        3'b110:  v = a | imm;
        3'b111:  v = a & imm;
        default: begin
          lng = 1;
          v = (in[6:0] == OP_ALUR && in[30]) ? a - imm : a + imm;
        end
      endcase
    end
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] rnd;
    logic [2:0]  f3;
    logic [4:0]  rd, a, b;
    int          k;
    rnd = $urandom;
    rd = 5'($urandom_range(0, 7));
    a  = 5'($urandom_range(0, 7));
    b  = 5'($urandom_range(0, 7));
    k  = $urandom_range(0, 3);
    f3 = (k == 0) ? 3'b000 : (k == 1) ? 3'b100 : (k == 2) ? 3'b110 : 3'b111;
    case ($urandom_range(0, 9))
      0:       return {rnd[31:20], a, 3'b011, rd, OP_LD};
      1:       return enc_s(a, b);
      2:       return enc_b(a, b);
      3, 4, 5: return enc_i(f3, rd, a, rnd[11:0]);
      6, 7, 8: return enc_r((f3 == 3'b000 && rnd[0]) ? 7'h20 : 7'h00, b, a, f3, rd);
      default: return {rnd[31:7], 7'b1010101};
    endcase
  endfunction

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic        wsv; logic [4:0] wsr; logic [63:0] wsd;
    logic        wlv; logic [4:0] wlr; logic [63:0] wld;
    logic        jmp;
    logic        ev; logic [31:0] ei; logic er; logic eh;
    logic [1:0]  cr; logic [63:0] e1; logic [63:0] e2;
  } vec_t;
  vec_t vq[$];

  task automatic row(input logic iv, input logic [31:0] in,
                     input logic wsv, input logic [4:0] wsr, input logic [63:0] wsd,
                     input logic wlv, input logic [4:0] wlr, input logic [63:0] wld,
                     input logic jmp, input logic ev, input logic [31:0] ei,
                     input logic er, input logic eh, input logic [1:0] cr,
                     input logic [63:0] e1, input logic [63:0] e2);
    vq.push_back('{iv, in, wsv, wsr, wsd, wlv, wlr, wld, jmp, ev, ei, er, eh, cr, e1, e2});
  endtask

  task automatic idle_in();
    if_valid = 0; if_inst = '0; if_addr = '0; jmp_valid = 0;
    wbs_valid = 0; wbs_rd = '0; wbs_value = '0;
    wbl_valid = 0; wbl_rd = '0; wbl_value = '0;
  endtask

  // ---------------- random-run model state ----------------
  typedef struct { logic [31:0] inst; logic [63:0] addr; } fe_t;
  typedef struct { int cyc; bit lng; logic [4:0] rd; logic [63:0] val; } wb_t;
  fe_t         fq[$];
  wb_t         wbq[$];
  logic [63:0] arch [32];
  int          now;

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 0;
    foreach (wbq[k])
      if (wbq[k].rd == r && (wbq[k].cyc > now || (!BYP && wbq[k].cyc == now))) return 1;
    return 0;
  endfunction

  logic [31:0] A1, A2, A3, ADD5, ADD6, ADD7, ORI7, SD77, BEQ, NOP, XORI4, ADDI0, ADD11, EOF, ADD6B, ADD8;
  vec_t        r;

  initial begin
    A1    = enc_i(3'b000, 5'd1, 5'd0, 12'd5);
    A2    = enc_i(3'b000, 5'd2, 5'd0, 12'd7);
    A3    = enc_i(3'b100, 5'd3, 5'd0, 12'd1);
    ADD5  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd5);
    ADD6  = enc_r(7'h00, 5'd5, 5'd5, 3'b000, 5'd6);
    ADD7  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd7);
    ORI7  = enc_i(3'b110, 5'd7, 5'd0, 12'd3);
    SD77  = enc_s(5'd7, 5'd7);
    BEQ   = enc_b(5'd0, 5'd0);
    NOP   = enc_i(3'b000, 5'd0, 5'd0, 12'd0);
    XORI4 = enc_i(3'b100, 5'd4, 5'd0, 12'd9);
    ADDI0 = enc_i(3'b000, 5'd0, 5'd0, 12'd9);
    ADD11 = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd11);
    EOF   = 32'h0000007f;
    ADD6B = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6);
    ADD8  = enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd8);

    // iv inst | wbs | wbl | jmp | ev ei er eh cr e1 e2
    row(1, A1,    0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(1, A2,    0,0,0,    0,0,0,       0, 1,A1,   1,0,2'b01,0,0);
    row(1, A3,    0,0,0,    0,0,0,       0, 1,A2,   1,0,2'b01,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 1,A3,   1,0,2'b01,0,0);
    row(0, 0,     1,3,1,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(0, 0,     0,0,0,    1,1,5,       0, 0,0,    1,0,2'b00,0,0);
    row(0, 0,     0,0,0,    1,2,7,       0, 0,0,    1,0,2'b00,0,0);
    row(1, ADD5,  0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(1, ADD6,  0,0,0,    0,0,0,       0, 1,ADD5, 1,0,2'b11,5,7);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    0,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    0,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    0,0,2'b00,0,0);
`ifdef ID_WB_BYPASS_EN
    row(0, 0,     0,0,0,    1,5,'h1234,  0, 1,ADD6, 1,0,2'b11,'h1234,'h1234);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
`else
    row(0, 0,     0,0,0,    1,5,'h1234,  0, 0,0,    0,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 1,ADD6, 1,0,2'b11,'h1234,'h1234);
`endif
    row(1, ADD7,  0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(1, ORI7,  0,0,0,    0,0,0,       0, 1,ADD7, 1,0,2'b11,5,7);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    0,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    0,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 0,0,    0,0,2'b00,0,0);
`ifdef ID_WB_BYPASS_EN
    row(0, 0,     0,0,0,    1,7,12,      0, 1,ORI7, 1,0,2'b01,0,0);
    row(0, 0,     1,7,3,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(1, SD77,  0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
`else
    row(0, 0,     0,0,0,    1,7,12,      0, 0,0,    0,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 1,ORI7, 1,0,2'b01,0,0);
    row(1, SD77,  1,7,3,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
`endif
    row(0, 0,     0,0,0,    0,0,0,       0, 1,SD77, 1,0,2'b11,3,3);
    row(1, BEQ,   0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(1, NOP,   0,0,0,    0,0,0,       0, 1,BEQ,  1,0,2'b11,0,0);
    row(1, NOP,   0,0,0,    0,0,0,       1, 0,0,    0,0,2'b00,0,0);
    row(1, XORI4, 0,0,0,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(0, 0,     0,0,0,    0,0,0,       0, 1,XORI4,1,0,2'b01,0,0);
    row(1, ADDI0, 1,4,9,    0,0,0,       0, 0,0,    1,0,2'b00,0,0);
    row(1, ADD11, 0,0,0,    0,0,0,       0, 1,ADDI0,1,0,2'b01,0,0);
    row(1, EOF,   0,0,0,    1,0,9,       0, 1,ADD11,1,0,2'b11,0,0);
    row(1, A1,    0,0,0,    0,0,0,       0, 1,EOF,  1,0,2'b00,0,0);
    row(1, A1,    0,0,0,    0,0,0,       0, 0,0,    0,1,2'b00,0,0);

    // Reset state
    idle_in();
    rst = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", if_ready, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_inst", inst, 0);
    chk("rst_addr", inst_addr, 0);
    chk("rst_rs1", rs1_value, 0);
    chk("rst_rs2", rs2_value, 0);
    rst = 0;

    for (int i = 0; i < vq.size(); i++) begin
      r = vq[i];
      @(negedge clk);
      if_valid = r.iv; if_inst = r.inst; if_addr = 64'(i * 4);
      wbs_valid = r.wsv; wbs_rd = r.wsr; wbs_value = r.wsd;
      wbl_valid = r.wlv; wbl_rd = r.wlr; wbl_value = r.wld;
      jmp_valid = r.jmp;
      #1;
      chk($sformatf("vec%0d_valid", i), inst_valid, r.ev);
      chk($sformatf("vec%0d_ready", i), if_ready, r.er);
      chk($sformatf("vec%0d_halted", i), halted, r.eh);
      if (r.ev) chk($sformatf("vec%0d_inst", i), inst, r.ei);
      if (r.ev && r.cr[0]) chk($sformatf("vec%0d_rs1", i), rs1_value, r.e1);
      if (r.ev && r.cr[1]) chk($sformatf("vec%0d_rs2", i), rs2_value, r.e2);
    end

    // Halted hold for 10 cycles, then reset releases it
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_in(); if_valid = 1; if_inst = A1;
      #1;
      chk("halt_ready", if_ready, 0);
      chk("halt_flag", halted, 1);
      chk("halt_valid", inst_valid, 0);
    end
    @(negedge clk);
    rst = 1; #1;
    chk("halt_rst_ready", if_ready, 0);
    @(negedge clk);
    rst = 0; idle_in(); #1;
    chk("halt_rst_flag", halted, 0);
    chk("halt_rst_ready2", if_ready, 1);
    chk("halt_rst_valid", inst_valid, 0);

    // Reset while a consumer is stalled on pending x5
    @(negedge clk); if_valid = 1; if_inst = ADD5; #1;
    chk("ms_ready0", if_ready, 1);
    @(negedge clk); if_inst = ADD6B; #1;
    chk("ms_issue_add5", inst_valid, 1);
    chk("ms_inst_add5", inst, ADD5);
    @(negedge clk); if_valid = 0; #1;
    chk("ms_stalled", inst_valid, 0);
    chk("ms_stalled_ready", if_ready, 0);
    @(negedge clk); rst = 1; wbl_valid = 1; wbl_rd = 5'd5; wbl_value = 64'hdead; #1;
    chk("ms_rst_ready", if_ready, 0);
    chk("ms_rst_valid", inst_valid, 0);
    @(negedge clk); rst = 0; idle_in(); if_valid = 1; if_inst = ADD8; #1;
    chk("ms_post_ready", if_ready, 1);
    chk("ms_post_valid", inst_valid, 0);
    @(negedge clk); if_valid = 0; #1;
    chk("ms_add8_valid", inst_valid, 1);
    chk("ms_add8_inst", inst, ADD8);
    chk("ms_add8_rs1", rs1_value, 0);

    // Randomized run against the in-order model
    begin
      fe_t         e;
      logic [31:0] cur, ci;
      logic [63:0] caddr, v;
      bit          brw, nbrw, exp_iss, exp_rdy, r1, r2, w, lng;
      int          issued;
      @(negedge clk); rst = 1; idle_in();
      @(negedge clk); rst = 0;
      fq.delete(); wbq.delete();
      for (int k = 0; k < 32; k++) arch[k] = '0;
      now = 0; brw = 0; issued = 0;
      cur = gen(); caddr = 64'h1000;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        idle_in();
        foreach (wbq[k]) begin
          if (wbq[k].cyc == now) begin
            if (wbq[k].lng) begin wbl_valid = 1; wbl_rd = wbq[k].rd; wbl_value = wbq[k].val; end
            else            begin wbs_valid = 1; wbs_rd = wbq[k].rd; wbs_value = wbq[k].val; end
          end
        end
        if_valid = ($urandom_range(0, 9) < 7);
        if_inst = cur; if_addr = caddr;
        jmp_valid = 1'($urandom_range(0, 1));
        #1;
        exp_iss = 0;
        if (fq.size() > 0 && !brw) begin
          ci = fq[0].inst;
          dec(ci, r1, r2, w);
          exp_iss = !((r1 && pend(ci[19:15])) || (r2 && pend(ci[24:20])) || (w && pend(ci[11:7])));
        end
        exp_rdy = !brw && (fq.size() == 0 || exp_iss);
        chk("rnd_valid", inst_valid, exp_iss);
        chk("rnd_ready", if_ready, exp_rdy);
        nbrw = 0;
        if (exp_iss) begin
          e = fq.pop_front();
          dec(e.inst, r1, r2, w);
          chk("rnd_inst", inst, e.inst);
          chk("rnd_addr", inst_addr, e.addr);
          if (r1) chk("rnd_rs1", rs1_value, arch[e.inst[19:15]]);
          if (r2) chk("rnd_rs2", rs2_value, arch[e.inst[24:20]]);
          if (w) begin
            exec(e.inst, arch[e.inst[19:15]], arch[e.inst[24:20]], v, lng);
            if (e.inst[11:7] != 5'd0) arch[e.inst[11:7]] = v;
            wbq.push_back('{now + (lng ? 4 : 1), lng, e.inst[11:7], v});
          end
          if (e.inst[6:0] == OP_BR) nbrw = 1;
          issued++;
        end
        if (if_valid && exp_rdy) begin
          fq.push_back('{cur, caddr});
          cur = gen(); caddr = caddr + 64'd4;
        end
        if (brw && jmp_valid) fq.delete();
        brw = nbrw;
        for (int k = wbq.size() - 1; k >= 0; k--)
          if (wbq[k].cyc <= now) wbq.delete(k);
        now++;
      end
      chk("rnd_progress", 64'(issued > 200), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_issue.md
# id_issue

Decode/issue stage sitting directly upstream of the four-stage execute pipeline. It does three things:
- Holds one fetched instruction in a single-entry buffer.
- Reads operands from a 32×64-bit register file that it owns.
- Tracks pending destination registers in a scoreboard, and issues one instruction per cycle to EX0 once RAW, WAW and branch hazards are clear.

Both execute writeback paths (short: EX0 logic ops; long: EX3 add/sub/load) write the register file here.

## Interface

Parameters:
- `XLEN`, 64, register and datapath width.
- `NREG`, 32, architectural register count; x0 reads as zero.

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_if_valid`  in  1  fetch presents an instruction.
- `i_if_inst`  in  32  instruction word.
- `i_if_addr`  in  64  instruction address.
- `o_if_ready`  out  1  buffer accepts this cycle; transfer when `i_if_valid & o_if_ready`.
- `o_inst_valid`  out  1  issue strobe to EX0, one cycle per instruction.
- `o_inst`  out  32  issued instruction.
- `o_inst_addr`  out  64  issued address.
- `o_rs1_value`  out  64  rs1 operand.
- `o_rs2_value`  out  64  rs2 operand.
- `i_wbs_valid`  in  1  short-path writeback (from EX0).
- `i_wbs_rd`  in  5  short-path destination register.
- `i_wbs_value`  in  64  short-path data.
- `i_wbl_valid`  in  1  long-path writeback (from EX3).
- `i_wbl_rd`  in  5  long-path destination register.
- `i_wbl_value`  in  64  long-path data.
- `i_jmp_valid`  in  1  taken branch resolved in EX0.
- `o_halted`  out  1  EOF issued; block is idle until reset.

## Operation

Instruction classes, by opcode:

| Opcode | Class | Reads | Writes rd |
|---|---|---|---|
| 0000011 | LD | rs1 | yes |
| 0100011 | SD | rs1, rs2 | no |
| 1100011 | BEQ/BNE | rs1, rs2 | no |
| 0010011 | I-ALU | rs1 | yes |
| 0110011 | R-ALU | rs1, rs2 | yes |
| 1111111 | EOF | none | no |

Unknown opcodes are issued with no reads and no writes.

Scoreboard:
- One pending bit per register. Bit 0 is never set.
- The bit for rd is set on the edge that issues a writing instruction with rd≠0.
- A bit is cleared on the edge where `i_wbs_valid` or `i_wbl_valid` names that register. If a set and a clear land on the same register in the same cycle, set wins.

Issue condition (evaluated every cycle):
- The buffer is valid.
- No register the instruction reads is pending.
- rd is not pending (WAW: a short-path write could otherwise overtake a long-path write).
- `br_wait` = 0.
- `o_halted` = 0.

Register file:
- Two write ports, both written on the edge.
- The two write ports never target the same rd in the same cycle; the WAW stall guarantees this.
- Writes to x0 are discarded.
- Operand outputs are combinational reads of the buffered instruction's rs1/rs2.

Branch handling:
- Issuing a branch sets `br_wait` on that edge.
- During the `br_wait` cycle the branch is in EX0 and `i_jmp_valid` is sampled.
- On the next edge `br_wait` clears. If `i_jmp_valid` was 1, the buffer is invalidated (fetch redirects itself).
- `o_if_ready` is 0 while `br_wait` = 1.

EOF handling:
- EOF issues like any other instruction.
- On that edge `o_halted` goes to 1 and `o_if_ready` is held at 0 until reset.

`o_if_ready` = `!o_halted & !br_wait & (buffer empty | issuing this cycle)`.

## Timing

- Reset values:
  - `o_inst_valid` = 0, `o_if_ready` = 0 while `i_rst` is high, `o_halted` = 0.
  - Buffer is empty, `br_wait` = 0, all scoreboard bits = 0.
  - All registers = 0.
  - `o_inst`, `o_inst_addr`, `o_rs1_value`, `o_rs2_value` = 0.
- Reset mid-operation discards the buffered instruction and clears the scoreboard. Writebacks arriving during reset are ignored.
- Latency, with no hazard and the buffer empty:
  - An instruction accepted at edge N is issued during cycle N+1 (`o_inst_valid` high).
  - EX0 captures it at edge N+2.
- Back-to-back issue: an instruction can be accepted on the same edge that the previous one issues, giving a sustained rate of 1 per cycle.
- Dependent instruction after a short-path producer: the producer's writeback is asserted in the cycle after it issues.
- Dependent instruction after a long-path producer: writeback arrives 4 cycles after issue.
- A branch costs 1 bubble cycle whether taken or not.

## Configuration

`ID_WB_BYPASS_EN`:
- **Defined:** a writeback arriving in the current cycle is forwarded combinationally onto `o_rs1_value`/`o_rs2_value`, and it counts as clearing the pending bit for the issue check in that same cycle. A consumer issues in the same cycle its producer writes back.
- **Undefined:** no forwarding. The consumer issues the cycle after the writeback edge, one extra bubble per dependency.

## Test plan

- **Independent ALU stream.** Reset, then feed ADDI x1,x0,5; ADDI x2,x0,7; XORI x3,x0,1 back-to-back. Expect `o_inst_valid` high on 3 consecutive cycles, `o_if_ready` never low, rs1 value = 0 each time.
- **RAW on long path.** Sequence ADD x5,x1,x2 → ADD x6,x5,x5. Drive `i_wbl` (rd=5, value=0x1234) 4 cycles after the first issue. With bypass: the second instruction issues in that cycle with rs1 = rs2 = 0x1234. Without bypass: it issues one cycle later with the same values.
- **WAW stall.** Sequence ADD x7,… → ORI x7,… . ORI is held until the `i_wbl` for x7 arrives, then issues. The final x7 equals the ORI result.
- **Taken branch.** BEQ issues, NOP is buffered, `i_jmp_valid` = 1 in the `br_wait` cycle. Expect one bubble, the buffer flushed (NOP never issued), and `o_if_ready` back to 1 on the next cycle.
- **Writes to x0 and EOF.** ADDI x0,x0,9 followed by a read of x0 gives 0, and no scoreboard stall occurs. Then issue EOF: `o_halted` = 1 on the next cycle, `o_if_ready` stays 0 for 10 cycles, and `i_rst` clears both.
- **Reset mid-stall.** Assert `i_rst` while an instruction is stalled on pending x5. After reset, x5 is not pending, the buffer is empty, and a new ADD x8,x5,x0 issues immediately with rs1 = 0.
